// File: rtl/seq_pkg.sv
// Shared definitions for the serial pattern generator and its detector-side debug decode.
package seq_pkg;

    localparam int LEN_W  = 4;
    localparam int REPS_W = 4;

    localparam logic [2:0] IDLE  = 3'b000;
    localparam logic [2:0] SHIFT = 3'b010;
    localparam logic [2:0] GAP   = 3'b011;
    localparam logic [2:0] DONE  = 3'b100;

    typedef enum logic [2:0] {
        S_IDLE  = IDLE,
        S_SHIFT = SHIFT,
        S_GAP   = GAP,
        S_DONE  = DONE
    } state_t;

    // Zero or over-long lengths fall back to the full register width.
    function automatic logic [LEN_W-1:0] eff_len(input logic [LEN_W-1:0] len, input int width);
        if (len == '0 || int'(len) > width)
            return LEN_W'(width);
        return len;
    endfunction

endpackage

// File: rtl/seq_pattern_gen_if.sv
// Pattern load handshake between a stimulus master and the generator.
interface seq_pattern_gen_if
    import seq_pkg::*;
#(
    parameter int WIDTH = 8
) ();
    logic              load_valid;
    logic              load_ready;
    logic [WIDTH-1:0]  load_data;
    logic [LEN_W-1:0]  load_len;
    logic [REPS_W-1:0] load_reps;

    modport master (output load_valid, load_data, load_len, load_reps, input load_ready);
    modport slave  (input load_valid, load_data, load_len, load_reps, output load_ready);
endinterface

// File: rtl/seq_shift_reg.sv
// Loadable pattern register with a down-counting bit index; cur_bit is the bit under the index.
module seq_shift_reg
    import seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic             reload,
    input  logic             shift,
    input  logic [WIDTH-1:0] load_data,
    input  logic [LEN_W-1:0] load_len,
    output logic             cur_bit,
    output logic             last_bit
);

    logic [WIDTH-1:0] data;
    logic [LEN_W-1:0] len;
    logic [LEN_W-1:0] idx;

    always_ff @(posedge clock) begin
        if (reset) begin
            data <= '0;
            len  <= '0;
            idx  <= '0;
        end else if (load) begin
            data <= load_data;
            len  <= load_len;
            idx  <= load_len - LEN_W'(1);
        end else if (reload) begin
            idx  <= len - LEN_W'(1);
        end else if (shift) begin
            idx  <= idx - LEN_W'(1);
        end
    end

    // Explicit mux keeps the 4-bit index from selecting past WIDTH.
    always_comb begin
        cur_bit = 1'b0;
        for (int i = 0; i < WIDTH; i++)
            if (idx == LEN_W'(i))
                cur_bit = data[i];
    end

    assign last_bit = (idx == '0);

endmodule

// File: rtl/seq_pattern_gen.sv
// Serial pattern generator: loads a word, shifts it out MSB-first with optional repeats and idle gaps.
module seq_pattern_gen
    import seq_pkg::*;
#(
    parameter int   WIDTH      = 8,
    parameter int   GAP_CYCLES = 0,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic                    clock,
    input  logic                    reset,
    seq_pattern_gen_if.slave        ld,
    input  logic                    abort,
    output logic                    output_bit,
    output logic                    bit_valid,
    output logic                    busy,
    output logic                    done,
    output logic [2:0]              present_state
);

    localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);

    state_t            state, state_n;
    logic [REPS_W-1:0] reps_left;
    logic [3:0]        gap_cnt;
    logic              accept;
    logic              sr_load, sr_reload, sr_shift;
    logic              reps_dec, gap_load;
    logic              cur_bit, last_bit;

    assign ld.load_ready = (state == S_IDLE);
    // abort wins over a simultaneous load request
    assign accept = ld.load_valid && ld.load_ready && !abort;

    seq_shift_reg #(.WIDTH(WIDTH)) u_sr (
        .clock     (clock),
        .reset     (reset),
        .load      (sr_load),
        .reload    (sr_reload),
        .shift     (sr_shift),
        .load_data (ld.load_data),
        .load_len  (eff_len(ld.load_len, WIDTH)),
        .cur_bit   (cur_bit),
        .last_bit  (last_bit)
    );

    always_comb begin
        state_n   = state;
        sr_load   = 1'b0;
        sr_reload = 1'b0;
        sr_shift  = 1'b0;
        reps_dec  = 1'b0;
        gap_load  = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_n = S_SHIFT;
                    sr_load = 1'b1;
                end
            end
            S_SHIFT: begin
                if (abort) begin
                    state_n = S_IDLE;
                end else if (last_bit) begin
                    if (reps_left > REPS_W'(1)) begin
                        reps_dec = 1'b1;
                        if (GAP_CYCLES > 0) begin
                            state_n  = S_GAP;
                            gap_load = 1'b1;
                        end else begin
                            sr_reload = 1'b1;
                        end
                    end else begin
                        state_n = S_DONE;
                    end
                end else begin
                    sr_shift = 1'b1;
                end
            end
            S_GAP: begin
                if (abort) begin
                    state_n = S_IDLE;
                end else if (gap_cnt == '0) begin
                    state_n   = S_SHIFT;
                    sr_reload = 1'b1;
                end
            end
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= S_IDLE;
            reps_left <= '0;
            gap_cnt   <= '0;
        end else begin
            state <= state_n;
            if (sr_load)
                reps_left <= (ld.load_reps == '0) ? REPS_W'(1) : ld.load_reps;
            else if (reps_dec)
                reps_left <= reps_left - REPS_W'(1);
            if (gap_load)
                gap_cnt <= GAP_LAST;
            else if (state == S_GAP && gap_cnt != '0)
                gap_cnt <= gap_cnt - 4'd1;
        end
    end

    // Outputs decode only registered state, so no input reaches them combinationally.
    assign bit_valid     = (state == S_SHIFT);
    assign output_bit    = bit_valid ? cur_bit : IDLE_LEVEL;
    assign busy          = (state != S_IDLE);
    assign done          = (state == S_DONE);
    assign present_state = state;

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Scoreboard bench: two generators (no gap / idle-low, 2-cycle gap / idle-high) against a bit-list model.
module tb_seq_pattern_gen;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic [1:0] abort = '0;
    logic [1:0] ob, bv, bsy, dn, rdy;
    logic [1:0][2:0] ps;
    int cyc = 0;
    int checks = 0;
    int errors = 0;
    logic bit_q [2][$];
    int   done_q [2][$];
    logic [1:0] chk_rdy = '0;
    int n;

    seq_pattern_gen_if #(.WIDTH(8)) if0 ();
    seq_pattern_gen_if #(.WIDTH(8)) if1 ();

    assign rdy[0] = if0.load_ready;
    assign rdy[1] = if1.load_ready;

    seq_pattern_gen #(.WIDTH(8), .GAP_CYCLES(0), .IDLE_LEVEL(1'b0)) dut0 (
        .clock(clock), .reset(reset), .ld(if0), .abort(abort[0]),
        .output_bit(ob[0]), .bit_valid(bv[0]), .busy(bsy[0]), .done(dn[0]),
        .present_state(ps[0]));

    seq_pattern_gen #(.WIDTH(8), .GAP_CYCLES(2), .IDLE_LEVEL(1'b1)) dut1 (
        .clock(clock), .reset(reset), .ld(if1), .abort(abort[1]),
        .output_bit(ob[1]), .bit_valid(bv[1]), .busy(bsy[1]), .done(dn[1]),
        .present_state(ps[1]));

    initial forever #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    function automatic int gap_of(input int k);
        return (k == 0) ? 0 : 2;
    endfunction

    function automatic logic lvl_of(input int k);
        return (k == 0) ? 1'b0 : 1'b1;
    endfunction

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d cyc=%0d got=%0h want=%0h", name, k, cyc, act, exp);
        end
    endtask

    task automatic drive(input int k, input logic v, input logic [7:0] d, input logic [3:0] l, input logic [3:0] r);
        if (k == 0) begin
            if0.load_valid = v; if0.load_data = d; if0.load_len = l; if0.load_reps = r;
        end else begin
            if1.load_valid = v; if1.load_data = d; if1.load_len = l; if1.load_reps = r;
        end
    endtask

    // Called at a negedge; returns at the negedge showing the first bit. n = presentation cycle.
    task automatic do_load(input int k, input logic [7:0] d, input logic [3:0] ln, input logic [3:0] rp,
                           input int limit, input bit exp_done, output int n_out);
        int t, len, reps, cnt;
        t = 0;
        while (rdy[k] !== 1'b1 && t < 1000) begin
            @(negedge clock);
            t++;
        end
        chk("ready_wait", k, (t < 1000), 1);
        len  = (ln == 0 || ln > 8) ? 8 : int'(ln);
        reps = (rp == 0) ? 1 : int'(rp);
        cnt = 0;
        for (int r = 0; r < reps; r++)
            for (int i = len - 1; i >= 0; i--) begin
                if (cnt < limit) bit_q[k].push_back(d[i]);
                cnt++;
            end
        if (exp_done) done_q[k].push_back(cyc + len * reps + gap_of(k) * (reps - 1) + 1);
        n_out = cyc;
        drive(k, 1'b1, d, ln, rp);
        @(negedge clock);
        drive(k, 1'b0, 8'h00, 4'd0, 4'd0);
    endtask

    task automatic wait_idle(input int k);
        int t;
        t = 0;
        while (bsy[k] && t < 2000) begin
            @(negedge clock);
            t++;
        end
        chk("idle_wait", k, (t < 2000), 1);
    endtask

    task automatic chk_quiet(input string tag, input int k);
        chk({tag, "_valid"}, k, bv[k], 0);
        chk({tag, "_busy"},  k, bsy[k], 0);
        chk({tag, "_done"},  k, dn[k], 0);
        chk({tag, "_ready"}, k, rdy[k], 1);
        chk({tag, "_level"}, k, ob[k], lvl_of(k));
        chk({tag, "_state"}, k, ps[k], 3'b000);
    endtask

    // Monitor: pops the scoreboard whenever a DUT presents a bit or a done pulse.
    initial begin
        logic e;
        @(posedge clock);
        forever begin
            @(negedge clock);
            for (int k = 0; k < 2; k++) begin
                if (chk_rdy[k]) begin
                    chk("ready_after_done", k, rdy[k], 1);
                    chk_rdy[k] = 1'b0;
                end
                if (bv[k]) begin
                    if (bit_q[k].size() == 0) begin
                        checks++; errors++;
                        $display("FAIL extra_bit dut%0d cyc=%0d got=%0b want=no bit", k, cyc, ob[k]);
                    end else begin
                        e = bit_q[k].pop_front();
                        chk("bit", k, ob[k], e);
                    end
                end else begin
                    chk("idle_level", k, ob[k], lvl_of(k));
                end
                if (dn[k]) begin
                    chk("done_state", k, ps[k], 3'b100);
                    chk("done_bits_left", k, bit_q[k].size(), 0);
                    if (done_q[k].size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_done dut%0d cyc=%0d got=1 want=0", k, cyc);
                    end else begin
                        chk("done_cycle", k, cyc, done_q[k].pop_front());
                    end
                    chk_rdy[k] = 1'b1;
                end
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
        $fatal(1);
    end

    initial begin
        drive(0, 1'b0, 8'h00, 4'd0, 4'd0);
        drive(1, 1'b0, 8'h00, 4'd0, 4'd0);
        repeat (3) @(negedge clock);
        chk_quiet("reset", 0);
        chk_quiet("reset", 1);
        reset = 1'b0;
        @(negedge clock);
        chk("ready_post_reset", 0, rdy[0], 1);

        // 0x5A, len 8, single pass
        do_load(0, 8'h5A, 4'd8, 4'd1, 99, 1, n);
        chk("first_bit_valid", 0, bv[0], 1);
        chk("first_bit_value", 0, ob[0], 0);
        wait_idle(0);

        // 1010 x3 with gaps; a second load while busy must be ignored
        do_load(1, 8'h0A, 4'd4, 4'd3, 99, 1, n);
        while (cyc < n + 6) @(negedge clock);
        chk("busy_not_ready", 1, rdy[1], 0);
        drive(1, 1'b1, 8'hF5, 4'd8, 4'd1);
        @(negedge clock);
        drive(1, 1'b0, 8'h00, 4'd0, 4'd0);
        wait_idle(1);

        // length/repeat boundaries
        do_load(0, 8'hC3, 4'd0, 4'd2, 99, 1, n);  wait_idle(0);
        do_load(0, 8'h96, 4'd12, 4'd0, 99, 1, n); wait_idle(0);
        do_load(0, 8'h3C, 4'd5, 4'd0, 99, 1, n);  wait_idle(0);
        do_load(0, 8'h01, 4'd1, 4'd4, 99, 1, n);  wait_idle(0);
        do_load(1, 8'h02, 4'd2, 4'd2, 99, 1, n);  wait_idle(1);

        // abort on the 3rd bit of 0xFF
        do_load(0, 8'hFF, 4'd8, 4'd1, 3, 0, n);
        while (cyc < n + 3) @(negedge clock);
        abort[0] = 1'b1;
        @(negedge clock);
        abort[0] = 1'b0;
        chk_quiet("abort_shift", 0);

        // abort during a gap
        do_load(1, 8'h0B, 4'd4, 4'd3, 4, 0, n);
        while (cyc < n + 5) @(negedge clock);
        abort[1] = 1'b1;
        @(negedge clock);
        abort[1] = 1'b0;
        chk_quiet("abort_gap", 1);

        // reset mid-shift
        do_load(0, 8'h5A, 4'd8, 4'd2, 3, 0, n);
        while (cyc < n + 3) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        chk_quiet("reset_mid", 0);
        reset = 1'b0;
        @(negedge clock);

        // randomized jobs, both generators running concurrently
        for (int j = 0; j < 30; j++) begin
            int k;
            k = int'($urandom_range(0, 1));
            do_load(k, 8'($urandom), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 4)), 999, 1, n);
        end
        wait_idle(0);
        wait_idle(1);
        repeat (2) @(negedge clock);
        for (int k = 0; k < 2; k++) begin
            chk("bits_drained", k, bit_q[k].size(), 0);
            chk("dones_drained", k, done_q[k].size(), 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
